// File: rtl/pe_array_ctrl.sv
// Sequencer for a systolic PE array: weight preload, input streaming, skewed result collection.
// Optional abort support is compiled in with `define PE_CTRL_ABORT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; num_rows latched on acceptance
// S_PRELOAD| one weight row per cycle into the PEs (ARRAY_DIM cycles)
// S_COMPUTE| stream N inputs, drain skew, write N results (N+LAT cycles)
// S_DONE   | single-cycle done pulse, then back to idle
module pe_array_ctrl #(
  parameter int ARRAY_DIM = 4,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_rows,
`ifdef PE_CTRL_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic              p_en,
  output logic              c_en,
  output logic              wbuf_rd_en,
  output logic [ADDR_W-1:0] wbuf_addr,
  output logic              ibuf_rd_en,
  output logic [ADDR_W-1:0] ibuf_addr,
  output logic              obuf_wr_en,
  output logic [ADDR_W-1:0] obuf_addr
);

  localparam int LAT = 2 * ARRAY_DIM - 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRELOAD = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_W:0]    LAT_C    = (CNT_W + 1)'(LAT);
  localparam logic [CNT_W:0]    PRE_LAST = (CNT_W + 1)'(ARRAY_DIM - 1);
  localparam logic [CNT_W:0]    ONE_C    = (CNT_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0]  rows_q, rows_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              p_en_q, p_en_d;
  logic              c_en_q, c_en_d;
  logic              ibuf_rd_en_q, ibuf_rd_en_d;
  logic              obuf_wr_en_q, obuf_wr_en_d;
  logic [ADDR_W-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [ADDR_W-1:0] ibuf_addr_q, ibuf_addr_d;
  logic [ADDR_W-1:0] obuf_addr_q, obuf_addr_d;
  logic              abort_req;

`ifdef PE_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Down-counter tmr_q holds the cycles remaining in the current phase
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rows_d  = rows_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d = num_rows;
          if (num_rows != '0) begin
            state_d = S_PRELOAD;
            tmr_d   = PRE_LAST;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PRELOAD: begin
        if (abort_req) begin
          state_d = S_DONE;
        end else if (tmr_q == '0) begin
          state_d = S_COMPUTE;
          tmr_d   = {1'b0, rows_q} + LAT_C - ONE_C;
        end else begin
          tmr_d = tmr_q - ONE_C;
        end
      end
      S_COMPUTE: begin
        if (abort_req || tmr_q == '0) begin
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - ONE_C;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with state_q.
  // With tmr counting N+LAT-1 down to 0, inputs are read while tmr >= LAT
  // and results written during the final N cycles (tmr < N).
  always_comb begin
    busy_d       = (state_d == S_PRELOAD) || (state_d == S_COMPUTE);
    done_d       = (state_d == S_DONE);
    p_en_d       = (state_d == S_PRELOAD);
    c_en_d       = (state_d == S_COMPUTE);
    ibuf_rd_en_d = c_en_d && (tmr_d >= LAT_C);
    obuf_wr_en_d = c_en_d && (tmr_d < {1'b0, rows_d});
    wbuf_addr_d  = wbuf_addr_q;
    ibuf_addr_d  = ibuf_addr_q;
    obuf_addr_d  = obuf_addr_q;
    if (p_en_d) begin
      wbuf_addr_d = p_en_q ? wbuf_addr_q + ADDR_ONE : '0;
    end
    if (ibuf_rd_en_d) begin
      ibuf_addr_d = ibuf_rd_en_q ? ibuf_addr_q + ADDR_ONE : '0;
    end
    if (obuf_wr_en_d) begin
      obuf_addr_d = obuf_wr_en_q ? obuf_addr_q + ADDR_ONE : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      rows_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      p_en_q       <= 1'b0;
      c_en_q       <= 1'b0;
      ibuf_rd_en_q <= 1'b0;
      obuf_wr_en_q <= 1'b0;
      wbuf_addr_q  <= '0;
      ibuf_addr_q  <= '0;
      obuf_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      rows_q       <= rows_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      p_en_q       <= p_en_d;
      c_en_q       <= c_en_d;
      ibuf_rd_en_q <= ibuf_rd_en_d;
      obuf_wr_en_q <= obuf_wr_en_d;
      wbuf_addr_q  <= wbuf_addr_d;
      ibuf_addr_q  <= ibuf_addr_d;
      obuf_addr_q  <= obuf_addr_d;
    end
  end

`ifdef PE_CTRL_ABORT_EN
  logic aborted_q, aborted_d;

  // Sticky until the next accepted job so the host can read it after done
  always_comb begin
    aborted_d = aborted_q;
    if (state_q == S_IDLE && start) begin
      aborted_d = 1'b0;
    end else if ((state_q == S_PRELOAD || state_q == S_COMPUTE) && abort) begin
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= aborted_d;
    end
  end

  assign aborted = aborted_q;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign p_en       = p_en_q;
  assign c_en       = c_en_q;
  assign wbuf_rd_en = p_en_q;
  assign wbuf_addr  = wbuf_addr_q;
  assign ibuf_rd_en = ibuf_rd_en_q;
  assign ibuf_addr  = ibuf_addr_q;
  assign obuf_wr_en = obuf_wr_en_q;
  assign obuf_addr  = obuf_addr_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl; covers the abort path too when PE_CTRL_ABORT_EN is defined.
module tb_pe_array_ctrl;

  localparam int D   = 4;
  localparam int AW  = 8;
  localparam int CW  = 16;
  localparam int LAT = 2 * D - 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_rows;
  logic          busy, done, p_en, c_en;
  logic          wbuf_rd_en, ibuf_rd_en, obuf_wr_en;
  logic [AW-1:0] wbuf_addr, ibuf_addr, obuf_addr;
`ifdef PE_CTRL_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pe_array_ctrl #(.ARRAY_DIM(D), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_rows   (num_rows),
`ifdef PE_CTRL_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .busy       (busy),
    .done       (done),
    .p_en       (p_en),
    .c_en       (c_en),
    .wbuf_rd_en (wbuf_rd_en),
    .wbuf_addr  (wbuf_addr),
    .ibuf_rd_en (ibuf_rd_en),
    .ibuf_addr  (ibuf_addr),
    .obuf_wr_en (obuf_wr_en),
    .obuf_addr  (obuf_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {busy, done, p_en, c_en, wbuf_rd_en, ibuf_rd_en, obuf_wr_en}
  function automatic logic [31:0] ctl();
    return {25'b0, busy, done, p_en, c_en, wbuf_rd_en, ibuf_rd_en, obuf_wr_en};
  endfunction

  // Called right after a falling edge; start is sampled at the next rising edge (cycle 0).
  task automatic job(input int n, input int stray_a, input int stray_b, input int stop_at);
    int   total, c, n_done, n_wr;
    logic pre, comp, dn, ib, ob;
    total    = (n == 0) ? 2 : D + n + LAT + 2;
    num_rows = CW'(n);
    start    = 1'b1;
    n_done   = 0;
    n_wr     = 0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      start    = 1'b0;
      num_rows = 16'd5;
      if (n == 0) begin
        pre  = 1'b0;
        comp = 1'b0;
        dn   = (k == 1);
      end else begin
        pre  = (k <= D);
        comp = (k > D) && (k <= D + n + LAT);
        dn   = (k == D + n + LAT + 1);
      end
      c  = k - D - 1;
      ib = comp && (c < n);
      ob = comp && (c >= LAT);
      check($sformatf("n%0d cyc%0d ctl", n, k), ctl(),
            {25'b0, pre | comp, dn, pre, comp, pre, ib, ob});
      if (pre) check($sformatf("n%0d cyc%0d wbuf_addr", n, k), 32'(wbuf_addr), k - 1);
      if (ib)  check($sformatf("n%0d cyc%0d ibuf_addr", n, k), 32'(ibuf_addr), c % 256);
      if (ob)  check($sformatf("n%0d cyc%0d obuf_addr", n, k), 32'(obuf_addr), (c - LAT) % 256);
      n_done += int'(done);
      n_wr   += int'(obuf_wr_en);
      if (k == stray_a || k == stray_b) start = 1'b1;
      if (k == stop_at) return;
    end
    check($sformatf("n%0d done_count", n), n_done, 1);
    check($sformatf("n%0d obuf_wr_count", n), n_wr, n);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    num_rows = '0;
`ifdef PE_CTRL_ABORT_EN
    abort    = 1'b0;
`endif
    #12;
    check("reset ctl", ctl(), 0);
    check("reset addrs", {8'b0, wbuf_addr, ibuf_addr, obuf_addr}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    job(3, -1, -1, 0);
    job(0, -1, -1, 0);
    job(3, 3, 8, 0);
    job(2, 13, -1, 0);

    // Asynchronous reset in the middle of a job, away from any rising edge
    job(3, -1, -1, 7);
    #2 reset = 1'b0;
    #1;
    check("async_rst ctl", ctl(), 0);
    check("async_rst addrs", {8'b0, wbuf_addr, ibuf_addr, obuf_addr}, 0);
    @(negedge clk);
    check("rst_held ctl", ctl(), 0);
    reset = 1'b1;
    job(1, -1, -1, 0);

    job(300, -1, -1, 0);

`ifdef PE_CTRL_ABORT_EN
    num_rows = 16'd10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort pre c_en", 32'(c_en), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort done", 32'(done), 1);
    check("abort aborted", 32'(aborted), 1);
    check("abort c_en", 32'(c_en), 0);
    check("abort busy", 32'(busy), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort idle ctl", ctl(), 0);
    check("abort sticky", 32'(aborted), 1);
    num_rows = 16'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort cleared", 32'(aborted), 0);
    check("abort next p_en", 32'(p_en), 1);
    repeat (14) @(negedge clk);
    check("abort next idle", ctl(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for an ARRAY_DIM x ARRAY_DIM systolic array of PE cells.
- On a start request, it preloads one weight row per cycle (p_en), then streams num_rows input vectors (c_en). It then collects the skewed results into the output buffer and signals done.
- Sits between the host command interface and the weight, input and output buffers plus the PE grid.

Parameters:
- ARRAY_DIM, 4, PE rows/columns; LAT = 2*ARRAY_DIM-2 is the skew latency.
- ADDR_W, 8, buffer address width.
- CNT_W, 16, width of the num_rows field and of internal counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  1-cycle command pulse; sampled only in IDLE
- num_rows  in  CNT_W  input vectors to stream; latched on an accepted start
- busy  out  1  high in PRELOAD/COMPUTE
- done  out  1  1-cycle pulse at job completion
- p_en  out  1  PE preload enable
- c_en  out  1  PE compute enable
- wbuf_rd_en  out  1  weight buffer read strobe
- wbuf_addr  out  ADDR_W  weight row address
- ibuf_rd_en  out  1  input buffer read strobe
- ibuf_addr  out  ADDR_W  input vector address
- obuf_wr_en  out  1  output buffer write strobe
- obuf_addr  out  ADDR_W  result row address

Behaviour:
- Reset (reset=0, async): state=IDLE; counters and latched num_rows = 0; every output = 0.
- FSM states: IDLE, PRELOAD, COMPUTE, DONE. All outputs are registered (Moore), so each output reflects the current state and counters.
- IDLE:
  - start=1 and num_rows!=0: latch num_rows, go to PRELOAD next cycle.
  - start=1 and num_rows==0: go directly to DONE; no buffer or PE enables fire.
- PRELOAD: lasts ARRAY_DIM cycles.
  - p_en=1, wbuf_rd_en=1.
  - wbuf_addr = 0..ARRAY_DIM-1, incrementing each cycle.
  - Then go to COMPUTE.
- COMPUTE: lasts N+LAT cycles (N = latched num_rows), with compute index c = 0..N+LAT-1.
  - c_en=1 throughout.
  - ibuf_rd_en=1 and ibuf_addr=c for c<N; otherwise ibuf_rd_en=0 and ibuf_addr holds its last value.
  - obuf_wr_en=1 and obuf_addr=c-LAT for LAT<=c<N+LAT.
  - Then go to DONE.
- DONE: lasts 1 cycle.
  - done=1, busy=0, all enables 0.
  - Return to IDLE.
  - A start in the DONE cycle is ignored.
- start while busy or in DONE: ignored, no effect on the running job.
- Addresses wrap modulo 2^ADDR_W when N > 2^ADDR_W; the caller's buffer is responsible for the wrap.
- Counter width: internal compute counter is CNT_W+1 bits, so N+LAT cannot overflow.
- Reset asserted mid-job: immediate return to IDLE with all outputs 0; no done pulse.
- p_en and c_en are never high in the same cycle.

Optional Feature:
- Macro: PE_CTRL_ABORT_EN.
- With the macro defined:
  - Extra input abort (1 bit).
  - abort=1 in PRELOAD or COMPUTE forces DONE on the next cycle; all enables drop in that same next cycle.
  - done pulses, and extra output aborted (1 bit) is high alongside done.
  - aborted clears on the next accepted start or on reset.
  - abort in IDLE or DONE is ignored.
- Without the macro: neither port exists; jobs always run to completion.

Test Plan:
- ARRAY_DIM=4, num_rows=3, start at cycle 0:
  - p_en/wbuf_rd_en high cycles 1-4, wbuf_addr 0,1,2,3.
  - c_en high cycles 5-13; ibuf_rd_en cycles 5-7, addr 0,1,2.
  - obuf_wr_en cycles 11-13, obuf_addr 0,1,2.
  - done at cycle 14; busy high cycles 1-13.
- num_rows=0 start at cycle 0 -> done at cycle 1; p_en, c_en, all rd/wr strobes stay 0; busy stays 0.
- start pulses repeated at cycles 3 and 8 during the job above -> waveform identical to the first test; exactly one done.
- reset driven low at cycle 7 of the first test (async, mid-clock) -> all outputs 0 immediately. After release, a start with num_rows=1 gives:
  - PRELOAD 4 cycles, then COMPUTE 7 cycles (obuf_wr_en only on the last one, addr 0), then done.
- num_rows=300, ADDR_W=8 -> ibuf_addr runs 0..255 then 0..43; obuf_wr_en count = 300; done after 4+306 cycles.
- (PE_CTRL_ABORT_EN) abort at the 3rd COMPUTE cycle of a num_rows=10 job:
  - next cycle: done=1, aborted=1, c_en=0.
  - a subsequent start clears aborted.
